bp_cfg_sequencer: RTL and testbench
===================================

Name: bp_cfg_sequencer

Overview:
- Sequences the per-tile configuration-bus writes that bring a BlackParrot system out of reset for the selected processor config.
- After start, for every core tile it freezes the core, then writes core id, I$/D$ mode, CCE mode and boot PC.
- Once all cores are configured, it unfreezes them in core order.
- Sits between the host/reset logic and the config-bus fanout that feeds each core tile.

Parameters:
- num_core_p, 4, number of core tiles (cc_x_dim*cc_y_dim of the active config); legal range 1..64.
- cfg_addr_width_p, 16, config-bus register address width.
- cfg_data_width_p, 64, config-bus data width.
- vaddr_width_p, 39, virtual address width; the boot PC is truncated to this width.
- boot_pc_p, 39'h00_8000_0000, PC written to every core.
- icache_mode_p, 1, I$ mode value (1 = coherent normal).
- dcache_mode_p, 1, D$ mode value.
- cce_mode_p, 1, CCE mode value (1 = normal, 0 = uncached).
- auto_start_p, 1, if 1 the sequence starts on the first cycle after reset deasserts.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle start request.
- cfg_v_o  out  1  config write valid.
- cfg_ready_i  in  1  config bus accepts the write when cfg_v_o & cfg_ready_i.
- cfg_core_o  out  lg(num_core_p) (min 1)  destination core index.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  write data, zero-extended.
- busy_o  out  1  sequence in progress.
- done_o  out  1  sticky; set after the last unfreeze is accepted, cleared by reset or a new start.

Behaviour:
- Register map (addr: data):
  - FREEZE 0x0000: 1 or 0
  - CORE_ID 0x0004: core index
  - ICACHE_MODE 0x0008: icache_mode_p
  - DCACHE_MODE 0x000C: dcache_mode_p
  - CCE_MODE 0x0010: cce_mode_p
  - NPC 0x0020: boot_pc_p
- States: IDLE, CFG, UNFREEZE, DONE. Counters: core_cnt (0..num_core_p-1) and step_cnt (0..5).
- Reset: state=IDLE, counters=0. All outputs are 0.
  - With auto_start_p=1, the first post-reset cycle behaves as if start_i=1.
- IDLE or DONE with start_i (or the auto-start cycle) -> CFG. Counters are zeroed and done_o cleared on that edge.
- CFG:
  - cfg_v_o=1. The write is selected by step_cnt: 0 FREEZE=1, 1 CORE_ID, 2 ICACHE_MODE, 3 DCACHE_MODE, 4 CCE_MODE, 5 NPC.
  - On handshake, step_cnt increments.
  - When step 5 is accepted, step_cnt wraps to 0 and core_cnt increments.
  - After the last core's step 5: core_cnt resets to 0 and state -> UNFREEZE.
- UNFREEZE:
  - cfg_v_o=1 with FREEZE=0 to core_cnt.
  - On handshake core_cnt increments.
  - After the last core is accepted -> DONE with done_o=1.
- DONE: cfg_v_o=0, done_o=1, busy_o=0.
- Valid/ready rules:
  - cfg_v_o does not depend combinationally on cfg_ready_i.
  - While cfg_v_o=1 and not accepted, core/addr/data are held stable.
  - Back-to-back acceptance gives one write per cycle.
  - First cfg_v_o appears the cycle after the start edge. With ready tied high, total length is 7*num_core_p cycles.
- Outputs when not valid: cfg_core_o, cfg_addr_o and cfg_data_o are 0 whenever cfg_v_o=0.
- busy_o=1 exactly in CFG or UNFREEZE.
- start_i is ignored while busy_o=1.
- reset_i mid-sequence aborts immediately: the next cycle cfg_v_o=0, all state is cleared, and no partial write is re-issued. auto_start then restarts from core 0.
- num_core_p=1: cfg_core_o is 1 bit, always 0.
- Data widths: core index and boot PC are zero-extended to cfg_data_width_p.

Test Plan:
- Auto-start sequence: num_core_p=2, ready=1, release reset.
  - Required: 14 writes in this order:
    - c0: FREEZE=1, CORE_ID=0, 0x0008=1, 0x000C=1, 0x0010=1, 0x0020=0x80000000
    - c1: the same six writes with CORE_ID=1
    - unfreeze: c0 FREEZE=0, then c1 FREEZE=0
  - done_o rises on the cycle after the 14th handshake.
- Backpressure: ready low for 3 cycles during c0 step 2 -> addr 0x0008, data 1, core 0 held stable all 3 cycles. The sequence resumes with no duplicated or skipped writes.
- Ignored start: start_i pulse while busy -> no restart. The write count is still 7*num_core_p.
- Restart from DONE: start_i in DONE -> done_o clears next cycle and the full sequence reissues from c0 FREEZE=1.
- Mid-sequence reset: reset_i asserted during UNFREEZE of c1 with auto_start_p=0 -> cfg_v_o=0, busy_o=0, done_o=0 next cycle, and everything stays idle until start_i.
- Single core: num_core_p=1 with random ready (50%) -> exactly 7 accepted writes, all with cfg_core_o=0.

Source files
------------

// File: rtl/bp_cfg_sequencer.sv
// rtl/bp_cfg_sequencer.sv - per-tile config-bus write sequencer for BlackParrot bring-up
// Freezes and programs every core tile, then unfreezes them in core order.
module bp_cfg_sequencer #(
  parameter int num_core_p = 4,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int vaddr_width_p = 39,
  parameter logic [vaddr_width_p-1:0] boot_pc_p = 39'h00_8000_0000,
  parameter int icache_mode_p = 1,
  parameter int dcache_mode_p = 1,
  parameter int cce_mode_p = 1,
  parameter int auto_start_p = 1,
  localparam int core_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_width_lp-1:0]    cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam logic [1:0] st_idle     = 2'd0;
  localparam logic [1:0] st_cfg      = 2'd1;
  localparam logic [1:0] st_unfreeze = 2'd2;
  localparam logic [1:0] st_done     = 2'd3;

  localparam logic [cfg_addr_width_p-1:0] freeze_addr_lp  = cfg_addr_width_p'(32'h0000);
  localparam logic [cfg_addr_width_p-1:0] core_id_addr_lp = cfg_addr_width_p'(32'h0004);
  localparam logic [cfg_addr_width_p-1:0] icache_addr_lp  = cfg_addr_width_p'(32'h0008);
  localparam logic [cfg_addr_width_p-1:0] dcache_addr_lp  = cfg_addr_width_p'(32'h000C);
  localparam logic [cfg_addr_width_p-1:0] cce_addr_lp     = cfg_addr_width_p'(32'h0010);
  localparam logic [cfg_addr_width_p-1:0] npc_addr_lp     = cfg_addr_width_p'(32'h0020);

  logic [1:0]               state;
  logic [core_width_lp-1:0] core_cnt;
  logic [2:0]               step_cnt;
  logic                     auto_pending;
  logic                     handshake;
  logic                     last_core;
  logic                     go;

  assign handshake = cfg_v_o & cfg_ready_i;
  assign last_core = (core_cnt == core_width_lp'(num_core_p - 1));
  // auto_pending is armed by reset so the first free-running cycle acts as a start
  assign go        = start_i | auto_pending;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= st_idle;
      core_cnt     <= '0;
      step_cnt     <= '0;
      auto_pending <= (auto_start_p != 0);
    end else begin
      auto_pending <= 1'b0;
      case (state)
        st_idle, st_done: begin
          if (go) begin
            state    <= st_cfg;
            core_cnt <= '0;
            step_cnt <= '0;
          end
        end
        st_cfg: begin
          if (handshake) begin
            if (step_cnt == 3'd5) begin
              step_cnt <= '0;
              if (last_core) begin
                core_cnt <= '0;
                state    <= st_unfreeze;
              end else begin
                core_cnt <= core_cnt + 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + 3'd1;
            end
          end
        end
        st_unfreeze: begin
          if (handshake) begin
            if (last_core) begin
              core_cnt <= '0;
              state    <= st_done;
            end else begin
              core_cnt <= core_cnt + 1'b1;
            end
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

  always_comb begin
    cfg_v_o    = (state == st_cfg) || (state == st_unfreeze);
    busy_o     = cfg_v_o;
    done_o     = (state == st_done);
    cfg_core_o = cfg_v_o ? core_cnt : '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    if (state == st_cfg) begin
      case (step_cnt)
        3'd0: begin cfg_addr_o = freeze_addr_lp;  cfg_data_o = cfg_data_width_p'(1); end
        3'd1: begin cfg_addr_o = core_id_addr_lp; cfg_data_o = cfg_data_width_p'(core_cnt); end
        3'd2: begin cfg_addr_o = icache_addr_lp;  cfg_data_o = cfg_data_width_p'(icache_mode_p); end
        3'd3: begin cfg_addr_o = dcache_addr_lp;  cfg_data_o = cfg_data_width_p'(dcache_mode_p); end
        3'd4: begin cfg_addr_o = cce_addr_lp;     cfg_data_o = cfg_data_width_p'(cce_mode_p); end
        3'd5: begin cfg_addr_o = npc_addr_lp;     cfg_data_o = cfg_data_width_p'(boot_pc_p); end
        default: begin cfg_addr_o = '0; cfg_data_o = '0; end
      endcase
    end else if (state == st_unfreeze) begin
      cfg_addr_o = freeze_addr_lp;
      cfg_data_o = '0;
    end
  end

endmodule

// File: tb/tb_bp_cfg_sequencer.sv
// tb/tb_bp_cfg_sequencer.sv - self-checking bench for bp_cfg_sequencer
// Three instances cover two-core auto-start, two-core manual start and single-core configs.
module tb_bp_cfg_sequencer;

  typedef struct {
    int          core;
    logic [15:0] addr;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic start = 1'b0, ready = 1'b1;
  int   sel = 0;

  logic        a_v, a_busy, a_done, b_v, b_busy, b_done, c_v, c_busy, c_done;
  logic [0:0]  a_core, b_core, c_core;
  logic [15:0] a_addr, b_addr, c_addr;
  logic [63:0] a_data, b_data, c_data;

  bp_cfg_sequencer #(.num_core_p(2)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .start_i(start), .cfg_v_o(a_v), .cfg_ready_i(ready),
    .cfg_core_o(a_core), .cfg_addr_o(a_addr), .cfg_data_o(a_data), .busy_o(a_busy), .done_o(a_done));

  bp_cfg_sequencer #(.num_core_p(2), .auto_start_p(0)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .start_i(start), .cfg_v_o(b_v), .cfg_ready_i(ready),
    .cfg_core_o(b_core), .cfg_addr_o(b_addr), .cfg_data_o(b_data), .busy_o(b_busy), .done_o(b_done));

  bp_cfg_sequencer #(.num_core_p(1)) dut_c (
    .clk_i(clk), .reset_i(rst_c), .start_i(start), .cfg_v_o(c_v), .cfg_ready_i(ready),
    .cfg_core_o(c_core), .cfg_addr_o(c_addr), .cfg_data_o(c_data), .busy_o(c_busy), .done_o(c_done));

  logic        o_v, o_busy, o_done;
  logic [7:0]  o_core;
  logic [15:0] o_addr;
  logic [63:0] o_data;

  always_comb begin
    o_v = a_v; o_busy = a_busy; o_done = a_done;
    o_core = {7'd0, a_core}; o_addr = a_addr; o_data = a_data;
    if (sel == 1) begin
      o_v = b_v; o_busy = b_busy; o_done = b_done;
      o_core = {7'd0, b_core}; o_addr = b_addr; o_data = b_data;
    end else if (sel == 2) begin
      o_v = c_v; o_busy = c_busy; o_done = c_done;
      o_core = {7'd0, c_core}; o_addr = c_addr; o_data = c_data;
    end
  end

  int   vectors = 0, miscompares = 0;
  wr_t  exp_q[$];
  int   widx = 0, vcyc = 0;
  logic exp_done = 1'b0;
  logic start_req = 1'b0, rand_ready = 1'b0, pulse_mid = 1'b0, pulsed = 1'b0;
  int   stall_at = -1, stall_left = 0, stall_seen = 0;
  logic        held = 1'b0;
  logic [7:0]  h_core;
  logic [15:0] h_addr;
  logic [63:0] h_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected write order built from the register map: six programming writes per core, then unfreezes.
  task automatic build_exp(input int n);
    exp_q.delete();
    for (int c = 0; c < n; c++) begin
      exp_q.push_back('{c, 16'h0000, 64'd1});
      exp_q.push_back('{c, 16'h0004, 64'(c)});
      exp_q.push_back('{c, 16'h0008, 64'd1});
      exp_q.push_back('{c, 16'h000C, 64'd1});
      exp_q.push_back('{c, 16'h0010, 64'd1});
      exp_q.push_back('{c, 16'h0020, 64'h8000_0000});
    end
    for (int c = 0; c < n; c++) exp_q.push_back('{c, 16'h0000, 64'd0});
    widx = 0;
    vcyc = 0;
  endtask

  // One clock: sample outputs, drive inputs for the coming edge, score against the model.
  task automatic cycle();
    logic        v, busy, done;
    logic [7:0]  core;
    logic [15:0] addr;
    logic [63:0] data;
    @(negedge clk);
    v = o_v; busy = o_busy; done = o_done; core = o_core; addr = o_addr; data = o_data;
    if (v && stall_left > 0 && widx == stall_at) begin
      ready = 1'b0; stall_left--; stall_seen++;
    end else if (rand_ready) ready = 1'($urandom_range(0, 1));
    else ready = 1'b1;
    if (pulse_mid && !pulsed && v && widx == 5) begin
      start = 1'b1; pulsed = 1'b1;
    end else start = start_req;
    start_req = 1'b0;
    check("done", {63'd0, done}, {63'd0, exp_done});
    check("busy", {63'd0, busy}, {63'd0, v});
    if (!v) begin
      check("idle_core", {56'd0, core}, 64'd0);
      check("idle_addr", {48'd0, addr}, 64'd0);
      check("idle_data", data, 64'd0);
    end else begin
      vcyc++;
      if (held) begin
        check("hold_core", {56'd0, core}, {56'd0, h_core});
        check("hold_addr", {48'd0, addr}, {48'd0, h_addr});
        check("hold_data", data, h_data);
      end
      if (ready) begin
        if (widx < exp_q.size()) begin
          check($sformatf("w%0d_core", widx), {56'd0, core}, 64'(exp_q[widx].core));
          check($sformatf("w%0d_addr", widx), {48'd0, addr}, {48'd0, exp_q[widx].addr});
          check($sformatf("w%0d_data", widx), data, exp_q[widx].data);
        end else check("extra_write", 64'(widx), 64'(exp_q.size() - 1));
        widx++;
        if (widx == exp_q.size()) exp_done = 1'b1;
      end
    end
    if (start && !busy) exp_done = 1'b0;
    held = v && !ready;
    h_core = core; h_addr = addr; h_data = data;
  endtask

  task automatic run_until(input int target, input int budget);
    int n = 0;
    while (widx < target && n < budget) begin
      cycle();
      n++;
    end
    check("reach_target", 64'(widx), 64'(target));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_v", {63'd0, o_v}, 64'd0);
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_done", {63'd0, o_done}, 64'd0);
    check("rst_addr", {48'd0, o_addr}, 64'd0);

    // Auto-start, ready high: 14 writes in 14 valid cycles, then done.
    build_exp(2);
    rst_a = 1'b0;
    run_until(14, 100);
    check("auto_len", 64'(vcyc), 64'd14);
    cycle();
    check("auto_done", {63'd0, o_done}, 64'd1);

    // Restart from DONE with a 3-cycle stall on c0 step 2 and an ignored mid-run start.
    build_exp(2);
    stall_at = 2; stall_left = 3; stall_seen = 0;
    pulse_mid = 1'b1; pulsed = 1'b0;
    start_req = 1'b1;
    run_until(14, 200);
    check("stall_cycles", 64'(stall_seen), 64'd3);
    check("stall_len", 64'(vcyc), 64'd17);
    check("mid_start_applied", {63'd0, pulsed}, 64'd1);
    pulse_mid = 1'b0;
    cycle();
    check("restart_done", {63'd0, o_done}, 64'd1);

    // Random backpressure on a further restart.
    build_exp(2);
    rand_ready = 1'b1;
    start_req = 1'b1;
    run_until(14, 400);
    rand_ready = 1'b0;
    cycle();

    // Manual-start instance: stays idle until start, then reset during c1 unfreeze.
    sel = 1; held = 1'b0; exp_done = 1'b0;
    build_exp(2);
    rst_b = 1'b0;
    repeat (4) cycle();
    check("b_idle_widx", 64'(widx), 64'd0);
    start_req = 1'b1;
    run_until(13, 100);
    @(negedge clk);
    check("b_unfrz_core", {56'd0, o_core}, 64'd1);
    check("b_unfrz_addr", {48'd0, o_addr}, 64'd0);
    check("b_unfrz_v", {63'd0, o_v}, 64'd1);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_rst_v", {63'd0, o_v}, 64'd0);
    check("b_rst_busy", {63'd0, o_busy}, 64'd0);
    check("b_rst_done", {63'd0, o_done}, 64'd0);
    rst_b = 1'b0; held = 1'b0; exp_done = 1'b0;
    repeat (6) cycle();
    check("b_post_rst_widx", 64'(widx), 64'd13);
    build_exp(2);
    start_req = 1'b1;
    run_until(14, 100);
    check("b_len", 64'(vcyc), 64'd14);
    cycle();
    check("b_done", {63'd0, o_done}, 64'd1);

    // Single core with 50% ready.
    sel = 2; held = 1'b0; exp_done = 1'b0;
    build_exp(1);
    rand_ready = 1'b1;
    rst_c = 1'b0;
    run_until(7, 300);
    rand_ready = 1'b0;
    cycle();
    check("c_writes", 64'(widx), 64'd7);
    check("c_done", {63'd0, o_done}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
